video_tmds_encoder: RTL



---
 rtl/video_tmds_encoder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/video_tmds_encoder.sv
// -----------------------------------------------------------------------------
// video_tmds_encoder
//
// Purpose:
//   Converts the 4-bit-per-channel RGB / data-enable / sync stream coming from
//   the video output registers into three 10-bit DVI/TMDS symbols per pixel
//   clock. The path is a fixed 3-stage pipeline: input register with 8-bit
//   expansion and ones count, transition minimisation, then DC balancing with a
//   per-channel running disparity counter. Serialisation happens downstream.
//
// Ports:
//   clk            pixel clock
//   reset_n        asynchronous, active-low reset
//   video_r/g/b    4-bit colour components (expanded to 8 bits as {c,c})
//   video_de       data enable, 1 = active pixel
//   video_hsync    horizontal sync, input polarity
//   video_vsync    vertical sync, input polarity
//   video_oddline  odd output line flag (only consumed with scanlines)
//   scanlines      (VIDEO_TMDS_SCANLINES_EN only) halve intensity on odd lines
//   tmds_ch0       blue symbol, bit 0 transmitted first
//   tmds_ch1       green symbol
//   tmds_ch2       red symbol
//
// Build option:
//   VIDEO_TMDS_SCANLINES_EN  adds the scanlines input; when the macro is not
//                            defined video_oddline is ignored.
// -----------------------------------------------------------------------------
module video_tmds_encoder (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] video_r,
  input  logic [3:0] video_g,
  input  logic [3:0] video_b,
  input  logic       video_de,
  input  logic       video_hsync,
  input  logic       video_vsync,
  input  logic       video_oddline,
`ifdef VIDEO_TMDS_SCANLINES_EN
  input  logic       scanlines,
`endif
  output logic [9:0] tmds_ch0,
  output logic [9:0] tmds_ch1,
  output logic [9:0] tmds_ch2
);

  localparam logic [9:0] CTRL_00 = 10'h354;
  localparam logic [9:0] CTRL_01 = 10'h0AB;
  localparam logic [9:0] CTRL_10 = 10'h154;
  localparam logic [9:0] CTRL_11 = 10'h2AB;

  // Channel n occupies bits [4n+3:4n]: ch0 = blue, ch1 = green, ch2 = red.
  logic [11:0] rgb_in;
  assign rgb_in = {video_r, video_g, video_b};

  logic shift_en;
`ifdef VIDEO_TMDS_SCANLINES_EN
  assign shift_en = scanlines & video_oddline;
`else
  logic unused_oddline;
  assign unused_oddline = video_oddline;
  assign shift_en       = 1'b0;
`endif

  // Control pipe {de, vsync, hsync}, stages 1 and 2. Stage 3 consumes ctl2_q
  // directly, so the control symbol appears together with the data symbols.
  logic [2:0] ctl1_d, ctl1_q;
  logic [2:0] ctl2_d, ctl2_q;

  always_comb begin
    ctl1_d = {video_de, video_vsync, video_hsync};
    ctl2_d = ctl1_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl1_q <= 3'b000;
      ctl2_q <= 3'b000;
    end else begin
      ctl1_q <= ctl1_d;
      ctl2_q <= ctl2_d;
    end
  end

  logic       de_s2;
  logic [9:0] ctrl0_sym;
  assign de_s2 = ctl2_q[2];

  always_comb begin
    case (ctl2_q[1:0])
      2'b00:   ctrl0_sym = CTRL_00;
      2'b01:   ctrl0_sym = CTRL_01;
      2'b10:   ctrl0_sym = CTRL_10;
      default: ctrl0_sym = CTRL_11;
    endcase
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    logic [7:0]        d_d, d_q;
    logic [3:0]        n1_d, n1_q;
    logic [8:0]        qm_d, qm_q;
    logic [3:0]        qn1_d, qn1_q;
    logic [9:0]        sym_d, sym_q;
    logic signed [5:0] cnt_d, cnt_q;
    logic              use_xnor;
    logic signed [5:0] n1_s, n0_s;

    // Stage 1: expand to 8 bits, optional scanline dimming, ones count.
    always_comb begin
      d_d = {rgb_in[gi*4 +: 4], rgb_in[gi*4 +: 4]};
      if (shift_en) begin
        d_d = d_d >> 1;
      end
      n1_d = 4'($countones(d_d));
    end

    // Stage 2: transition minimisation. XNOR chaining is folded in as an
    // extra XOR with use_xnor on every bit after bit 0.
    always_comb begin : s2_logic
      logic [8:0] qm;
      use_xnor = (n1_q > 4'd4) || ((n1_q == 4'd4) && !d_q[0]);
      qm       = 9'd0;
      qm[0]    = d_q[0];
      for (int i = 1; i < 8; i++) begin
        qm[i] = qm[i-1] ^ d_q[i] ^ use_xnor;
      end
      qm[8] = ~use_xnor;
      qm_d  = qm;
      qn1_d = 4'($countones(qm[7:0]));
    end

    // Stage 3: DC balance. n1 == n0 is the same as n1 == 4.
    always_comb begin
      n1_s  = $signed({2'b00, qn1_q});
      n0_s  = 6'sd8 - n1_s;
      sym_d = sym_q;
      cnt_d = cnt_q;
      if (!de_s2) begin
        cnt_d = 6'sd0;
        sym_d = (gi == 0) ? ctrl0_sym : CTRL_00;
      end else if ((cnt_q == 6'sd0) || (qn1_q == 4'd4)) begin
        sym_d = {~qm_q[8], qm_q[8], (qm_q[8] ? qm_q[7:0] : ~qm_q[7:0])};
        cnt_d = cnt_q + (qm_q[8] ? (n1_s - n0_s) : (n0_s - n1_s));
      end else if (((cnt_q > 6'sd0) && (qn1_q > 4'd4)) ||
                   ((cnt_q < 6'sd0) && (qn1_q < 4'd4))) begin
        sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d = cnt_q + (qm_q[8] ? 6'sd2 : 6'sd0) + (n0_s - n1_s);
      end else begin
        sym_d = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d = cnt_q - (qm_q[8] ? 6'sd0 : 6'sd2) + (n1_s - n0_s);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        d_q   <= 8'd0;
        n1_q  <= 4'd0;
        qm_q  <= 9'd0;
        qn1_q <= 4'd0;
        sym_q <= CTRL_00;
        cnt_q <= 6'sd0;
      end else begin
        d_q   <= d_d;
        n1_q  <= n1_d;
        qm_q  <= qm_d;
        qn1_q <= qn1_d;
        sym_q <= sym_d;
        cnt_q <= cnt_d;
      end
    end
  end

  assign tmds_ch0 = g_ch[0].sym_q;
  assign tmds_ch1 = g_ch[1].sym_q;
  assign tmds_ch2 = g_ch[2].sym_q;

endmodule
